instr_encoder_loader: RTL

- Encoder-side counterpart of the control unit's opcode decode. Takes operation requests (ALU op class, register fields, immediate or funct) and encodes them into 32-bit instruction words using the processor's opcode map.
- Buffers encoded words in a small FIFO and streams them into instruction memory through a write handshake. Used by the testbench and boot path to load programs before the core is released.

---
 rtl/instr_encoder_loader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Purpose: encode ALU-class requests into 32-bit instruction words and stream them into instruction memory.
// Latency: an accepted request reaches mem_we/mem_wdata one cycle later when the buffer is empty.
// Backpressure: in_ready drops when the buffer is full or memory capacity is reached; mem_ready stalls the drain.

// Purpose: generic synchronous FIFO with first-word-fall-through head.
// Latency: a pushed word is visible on head_dat the cycle after the push.
// Backpressure: pushes are dropped when full, pops are ignored when empty.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointer and occupancy update; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    // Storage; cleared on reset so nothing stale survives a mid-session reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module instr_encoder_loader #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_WORDS  = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_end,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_aluop,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [11:0] in_imm,
    input  logic [3:0]  in_funct,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [6:0]  word_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } itype_t;

    typedef struct packed {
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } rtype_t;

    state_t        state;
    state_t        state_nxt;
    logic          start_sess;
    logic          accept_vld;
    logic          pop_vld;
    logic          at_cap;
    logic [31:0]   total_words;
    logic [31:0]   enc_dat;
    logic [31:0]   head_dat;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    itype_t        iword;
    rtype_t        rword;

    // Instruction encoding from the opcode map; funct3 is zero for every I-type class.
    always_comb begin
        iword        = '0;
        rword        = '0;
        iword.imm    = in_imm;
        iword.rs1    = in_rs1;
        iword.rd     = in_rd;
        rword.funct7 = {1'b0, in_funct[3], 5'b0};
        rword.rs2    = in_rs2;
        rword.rs1    = in_rs1;
        rword.funct3 = in_funct[2:0];
        rword.rd     = in_rd;
        rword.opcode = 7'b0110011;
        case (in_aluop)
            3'b000:  iword.opcode = 7'b0000111;
            3'b001:  iword.opcode = 7'b0001011;
            3'b010:  iword.opcode = 7'b0001111;
            3'b011:  iword.opcode = 7'b0011011;
            3'b100:  iword.opcode = 7'b0011111;
            3'b101:  iword.opcode = 7'b0100111;
            3'b110:  iword.opcode = 7'b0101011;
            default: iword.opcode = 7'b0110011;
        endcase
        enc_dat = (in_aluop == 3'b111) ? rword : iword;
    end

    // Words already written plus words still buffered bound what may be accepted.
    assign total_words = 32'(word_count) + 32'(fifo_count);
    assign at_cap      = (total_words >= 32'(MEM_WORDS));
    assign accept_vld  = in_valid && in_ready;

    assign mem_we    = !fifo_empty;
    assign mem_wdata = fifo_empty ? 32'h0 : head_dat;
    assign pop_vld   = mem_we && mem_ready;
    assign busy      = (state == LOAD) || (state == DRAIN);
    assign done      = (state == DONE);

    fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (accept_vld),
        .push_dat (enc_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    // Session state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and request-side handshake; load_start is only honoured outside a session.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        start_sess = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load_start) begin
                    state_nxt  = LOAD;
                    start_sess = 1'b1;
                end
            end
            LOAD: begin
                in_ready = !fifo_full && !at_cap;
                if (load_end) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write pointer, word counter and sticky overflow; the address parks on the last slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
            mem_addr   <= BASE_ADDR;
            overflow   <= 1'b0;
        end else if (start_sess) begin
            word_count <= '0;
            mem_addr   <= BASE_ADDR;
            overflow   <= 1'b0;
        end else begin
            if (pop_vld) begin
                word_count <= word_count + 7'd1;
                if (32'(word_count) < 32'(MEM_WORDS - 1)) mem_addr <= mem_addr + 32'd4;
            end
            if ((state == LOAD) && in_valid && at_cap) overflow <= 1'b1;
        end
    end
endmodule
